dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pkg.sv | 14 +
 rtl/dff_stage.sv | 46 ++++
 rtl/dff_pipe.sv | 106 ++++++++++
 tb/tb_dff_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared limits and occupancy-width helper for dff_pipe
package dff_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  // Bits needed to count 0..depth valid stages inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one pipeline stage: data register plus valid flag
module dff_stage
  import dff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  // Flush only drops the valid flag; data keeps its last value.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (en) begin
      data_d = d;
      vld_d  = d_vld;
    end
  end

  // Stage registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q     = data_q;
  assign q_vld = vld_q;

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - enabled register pipeline with occupancy count; DFF_PIPE_NQ_EN adds registered nQ
module dff_pipe
  import dff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          C,
  input  logic                          nR,
  input  logic [WIDTH-1:0]              D,
  input  logic                          D_VLD,
  input  logic                          EN,
  input  logic                          FLUSH,
  output logic [WIDTH-1:0]              Q,
  output logic                          Q_VLD,
`ifdef DFF_PIPE_NQ_EN
  output logic [WIDTH-1:0]              nQ,
`endif
  output logic [occ_width(DEPTH)-1:0]   OCC,
  output logic                          FULL,
  output logic                          EMPTY
);

  localparam int                OCC_W    = occ_width(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] stage_in  [DEPTH];
  logic [WIDTH-1:0] stage_q   [DEPTH];
  logic [DEPTH-1:0] stage_vin;
  logic [DEPTH-1:0] stage_vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in[i]  = D;
      assign stage_vin[i] = D_VLD;
    end else begin : g_link
      assign stage_in[i]  = stage_q[i-1];
      assign stage_vin[i] = stage_vld[i-1];
    end

    dff_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (C),
      .resetn (nR),
      .en     (EN),
      .flush  (FLUSH),
      .d      (stage_in[i]),
      .d_vld  (stage_vin[i]),
      .q      (stage_q[i]),
      .q_vld  (stage_vld[i])
    );
  end

  assign Q     = stage_q[DEPTH-1];
  assign Q_VLD = stage_vld[DEPTH-1];

  logic [OCC_W-1:0] occ_d, occ_q;

  // Occupancy tracks valid bits: one enters with D_VLD, one leaves with the pre-edge Q_VLD.
  always_comb begin
    occ_d = occ_q;
    if (FLUSH) begin
      occ_d = '0;
    end else if (EN) begin
      occ_d = occ_q + OCC_W'(D_VLD) - OCC_W'(Q_VLD);
    end
  end

  // Occupancy register.
  always_ff @(posedge C) begin
    if (!nR) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign OCC   = occ_q;
  assign FULL  = (occ_q == OCC_FULL);
  assign EMPTY = (occ_q == '0);

`ifdef DFF_PIPE_NQ_EN
  logic [WIDTH-1:0] nq_d, nq_q;

  // Inverted copy of the last stage, loaded from the same input so it is a true register.
  always_comb begin
    nq_d = nq_q;
    if (!FLUSH && EN) begin
      nq_d = ~stage_in[DEPTH-1];
    end
  end

  // Inverted last-stage register; resets to all ones to mirror Q=0.
  always_ff @(posedge C) begin
    if (!nR) begin
      nq_q <= '1;
    end else begin
      nq_q <= nq_d;
    end
  end

  assign nQ = nq_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4)
module tb_dff_pipe;

  logic       C;
  logic       nR;
  logic [7:0] D;
  logic       D_VLD;
  logic       EN;
  logic       FLUSH;
  logic [7:0] Q;
  logic       Q_VLD;
  logic [2:0] OCC;
  logic       FULL;
  logic       EMPTY;
`ifdef DFF_PIPE_NQ_EN
  logic [7:0] nQ;
`endif

  int pass_cnt;
  int total_cnt;

  dff_pipe #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .C     (C),
    .nR    (nR),
    .D     (D),
    .D_VLD (D_VLD),
    .EN    (EN),
    .FLUSH (FLUSH),
    .Q     (Q),
    .Q_VLD (Q_VLD),
`ifdef DFF_PIPE_NQ_EN
    .nQ    (nQ),
`endif
    .OCC   (OCC),
    .FULL  (FULL),
    .EMPTY (EMPTY)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    nR = 1'b0; EN = 1'b1; FLUSH = 1'b0; D = 8'hA5; D_VLD = 1'b1;
    tick();
    tick();
    total_cnt++; if (Q !== 8'h00) $display("FAIL reset_q got %h want %h", Q, 8'h00); else pass_cnt++;
    total_cnt++; if (Q_VLD !== 1'b0) $display("FAIL reset_qvld got %b want 0", Q_VLD); else pass_cnt++;
    total_cnt++; if (OCC !== 3'd0) $display("FAIL reset_occ got %0d want 0", OCC); else pass_cnt++;
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL reset_empty got %b want 1", EMPTY); else pass_cnt++;
    total_cnt++; if (FULL !== 1'b0) $display("FAIL reset_full got %b want 0", FULL); else pass_cnt++;
`ifdef DFF_PIPE_NQ_EN
    total_cnt++; if (nQ !== 8'hFF) $display("FAIL reset_nq got %h want ff", nQ); else pass_cnt++;
`endif
  endtask

  task automatic test_fill();
    logic [2:0] exp_occ [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    nR = 1'b1; EN = 1'b1; FLUSH = 1'b0; D_VLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = 8'(i + 1);
      tick();
      total_cnt++; if (OCC !== exp_occ[i]) $display("FAIL fill_occ%0d got %0d want %0d", i, OCC, exp_occ[i]); else pass_cnt++;
      if (i < 3) begin
        total_cnt++; if (Q_VLD !== 1'b0) $display("FAIL fill_qvld%0d got %b want 0", i, Q_VLD); else pass_cnt++;
      end
    end
    total_cnt++; if (Q !== 8'h01) $display("FAIL fill_q got %h want 01", Q); else pass_cnt++;
    total_cnt++; if (Q_VLD !== 1'b1) $display("FAIL fill_qvld got %b want 1", Q_VLD); else pass_cnt++;
    total_cnt++; if (FULL !== 1'b1) $display("FAIL fill_full got %b want 1", FULL); else pass_cnt++;
    total_cnt++; if (EMPTY !== 1'b0) $display("FAIL fill_empty got %b want 0", EMPTY); else pass_cnt++;
    D = 8'h05;
    tick();
    total_cnt++; if (Q !== 8'h02) $display("FAIL fill_next_q got %h want 02", Q); else pass_cnt++;
    total_cnt++; if (OCC !== 3'd4) $display("FAIL fill_next_occ got %0d want 4", OCC); else pass_cnt++;
`ifdef DFF_PIPE_NQ_EN
    total_cnt++; if (nQ !== 8'hFD) $display("FAIL fill_nq got %h want fd", nQ); else pass_cnt++;
`endif
  endtask

  task automatic test_stall();
    EN = 1'b0; D_VLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      D = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      total_cnt++; if (Q !== 8'h02) $display("FAIL stall_q%0d got %h want 02", i, Q); else pass_cnt++;
      total_cnt++; if (OCC !== 3'd4) $display("FAIL stall_occ%0d got %0d want 4", i, OCC); else pass_cnt++;
      total_cnt++; if (FULL !== 1'b1) $display("FAIL stall_full%0d got %b want 1", i, FULL); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    FLUSH = 1'b1; EN = 1'b1; D = 8'h77; D_VLD = 1'b1;
    tick();
    FLUSH = 1'b0; EN = 1'b0;
    total_cnt++; if (OCC !== 3'd0) $display("FAIL flush_occ got %0d want 0", OCC); else pass_cnt++;
    total_cnt++; if (EMPTY !== 1'b1) $display("FAIL flush_empty got %b want 1", EMPTY); else pass_cnt++;
    total_cnt++; if (Q !== 8'h02) $display("FAIL flush_q got %h want 02", Q); else pass_cnt++;
    total_cnt++; if (Q_VLD !== 1'b0) $display("FAIL flush_qvld got %b want 0", Q_VLD); else pass_cnt++;
`ifdef DFF_PIPE_NQ_EN
    total_cnt++; if (nQ !== 8'hFD) $display("FAIL flush_nq got %h want fd", nQ); else pass_cnt++;
`endif
  endtask

  task automatic test_bubble();
    logic [7:0] in_d   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       in_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] f_occ  [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
    logic [7:0] dr_q   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       dr_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] dr_occ [4] = '{3'd2, 3'd1, 3'd1, 3'd0};
    EN = 1'b1; FLUSH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      D = in_d[i]; D_VLD = in_v[i];
      tick();
      total_cnt++; if (OCC !== f_occ[i]) $display("FAIL bubble_fill_occ%0d got %0d want %0d", i, OCC, f_occ[i]); else pass_cnt++;
    end
    D = 8'h00; D_VLD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total_cnt++; if (Q !== dr_q[i]) $display("FAIL bubble_q%0d got %h want %h", i, Q, dr_q[i]); else pass_cnt++;
      total_cnt++; if (Q_VLD !== dr_v[i]) $display("FAIL bubble_qvld%0d got %b want %b", i, Q_VLD, dr_v[i]); else pass_cnt++;
      total_cnt++; if (OCC !== dr_occ[i]) $display("FAIL bubble_occ%0d got %0d want %0d", i, OCC, dr_occ[i]); else pass_cnt++;
    end
  endtask

  task automatic test_midstream_reset();
    EN = 1'b1; FLUSH = 1'b0; D_VLD = 1'b1;
    D = 8'hA1; tick();
    D = 8'hA2; tick();
    total_cnt++; if (OCC !== 3'd2) $display("FAIL mid_pre_occ got %0d want 2", OCC); else pass_cnt++;
    nR = 1'b0; D = 8'hA3;
    tick();
    total_cnt++; if (OCC !== 3'd0) $display("FAIL mid_rst_occ got %0d want 0", OCC); else pass_cnt++;
    total_cnt++; if (Q_VLD !== 1'b0) $display("FAIL mid_rst_qvld got %b want 0", Q_VLD); else pass_cnt++;
    nR = 1'b1; D = 8'hB1; D_VLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      D = 8'h00; D_VLD = 1'b0;
      if (i < 3) begin
        total_cnt++; if (Q_VLD !== 1'b0) $display("FAIL mid_lat_qvld%0d got %b want 0", i, Q_VLD); else pass_cnt++;
        total_cnt++; if (OCC !== 3'd1) $display("FAIL mid_lat_occ%0d got %0d want 1", i, OCC); else pass_cnt++;
      end
`ifdef DFF_PIPE_NQ_EN
      total_cnt++; if (nQ !== ~Q) $display("FAIL mid_nq%0d got %h want %h", i, nQ, ~Q); else pass_cnt++;
`endif
    end
    total_cnt++; if (Q !== 8'hB1) $display("FAIL mid_q got %h want b1", Q); else pass_cnt++;
    total_cnt++; if (Q_VLD !== 1'b1) $display("FAIL mid_qvld got %b want 1", Q_VLD); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    nR = 1'b0; EN = 1'b0; FLUSH = 1'b0; D = 8'h00; D_VLD = 1'b0;
    test_reset();
    test_fill();
    test_stall();
    test_flush();
    test_bubble();
    test_midstream_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
